// File: rtl/tone_if.sv
// Tone generator control bundle: sequencer drives div/enable/volume/retrig,
// generator returns buzzer and active.
interface tone_if #(
  parameter int WIDTH    = 17,
  parameter int VOL_BITS = 2
);
  logic [WIDTH-1:0]    div;
  logic                enable;
  logic [VOL_BITS-1:0] volume;
  logic                retrig;
  logic                buzzer;
  logic                active;

  modport master (
    output div, enable, volume, retrig,
    input  buzzer, active
  );

  modport slave (
    input  div, enable, volume, retrig,
    output buzzer, active
  );
endinterface

// File: rtl/tone_gen.sv
// Square-wave buzzer tone generator with glitch-free note change,
// PWM volume gating and re-trigger silence gap.
// Ports: clk, rst (sync, active-high), bus (tone_if.slave:
// div/enable/volume/retrig in, buzzer/active out).
module tone_gen #(
  parameter int WIDTH    = 17,
  parameter int VOL_BITS = 2,
  parameter int PWM_BITS = 3,
  parameter int GAP      = 2048
) (
  input  logic    clk,
  input  logic    rst,
  tone_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    MUTE
  } state_e;

  localparam int GW = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP - 1);
  localparam logic [PWM_BITS-1:0] LOW_ONES =
    PWM_BITS'((1 << (PWM_BITS - VOL_BITS)) - 1);

  state_e state_q, state_d;
  logic phase_q, phase_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic buzzer_q, buzzer_d;
  logic [PWM_BITS-1:0] thr;
  logic go;
  logic terminal;

  assign go = bus.enable & (bus.div != '0);
  assign terminal =
    (cnt_q == div_q - WIDTH'(1));
  // volume occupies the top bits; low bits
  // all ones so full volume never gates
  assign thr =
    (PWM_BITS'(bus.volume)
      << (PWM_BITS - VOL_BITS)) | LOW_ONES;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    gcnt_d   = gcnt_q;
    pwm_d    = pwm_q + PWM_BITS'(1);
    buzzer_d = phase_q
      & ((state_q == RUN) | (state_q == DRAIN))
      & (pwm_q <= thr);
    if (bus.retrig) begin
      state_d = MUTE;
      phase_d = 1'b0;
      gcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            state_d = RUN;
            div_d   = bus.div;
            cnt_d   = '0;
            phase_d = 1'b1;
          end
        end
        RUN: begin
          cnt_d = cnt_q + WIDTH'(1);
          if (terminal) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            if (bus.div != '0)
              div_d = bus.div;
          end
          // a high half in progress finishes
          // in DRAIN; otherwise stop at once
          if (!go) begin
            if (!phase_q || terminal) begin
              state_d = IDLE;
              phase_d = 1'b0;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt_d = cnt_q + WIDTH'(1);
          if (terminal) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            state_d = IDLE;
          end
        end
        MUTE: begin
          gcnt_d  = gcnt_q + GW'(1);
          phase_d = 1'b0;
          if (gcnt_q == GAP_LAST) begin
            if (go) begin
              state_d = RUN;
              div_d   = bus.div;
              cnt_d   = '0;
              phase_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      gcnt_q   <= '0;
      pwm_q    <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      gcnt_q   <= gcnt_d;
      pwm_q    <= pwm_d;
      buzzer_q <= buzzer_d;
    end
  end

  assign bus.buzzer = buzzer_q;
  assign bus.active = (state_q != IDLE);
endmodule

// File: tb/tb_tone_gen.sv
// Self-checking bench for tone_gen: segment table driven against a
// behavioural scoreboard model, plus hand-timed corner sequences.
module tb_tone_gen;
  localparam int W   = 17;
  localparam int VB  = 2;
  localparam int PB  = 3;
  localparam int GAP = 16;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_MUTE  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tone_if #(.WIDTH(W), .VOL_BITS(VB)) bus ();

  tone_gen #(
    .WIDTH(W), .VOL_BITS(VB),
    .PWM_BITS(PB), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic b;
    logic a;
  } exp_t;

  typedef struct {
    bit r;
    bit en;
    int div;
    int vol;
    bit rt;
    int n;
  } seg_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: m_rem = cycles left in current half
  int m_st  = S_IDLE;
  bit m_ph  = 0;
  int m_rem = 0;
  int m_gc  = 0;
  int m_pwm = 0;
  bit m_buz = 0;

  task automatic model_edge();
    bit go;
    bit nb;
    bit term;
    int pw;
    int thr;
    go  = bus.enable && (bus.div != 0);
    pw  = 1 << (PB - VB);
    thr = int'(bus.volume) * pw + pw - 1;
    nb  = m_ph && (m_st == S_RUN || m_st == S_DRAIN)
          && (m_pwm <= thr);
    m_pwm = (m_pwm + 1) % (1 << PB);
    m_buz = nb;
    if (rst) begin
      m_st = S_IDLE; m_ph = 0; m_rem = 0;
      m_gc = 0; m_pwm = 0; m_buz = 0;
    end else if (bus.retrig) begin
      m_st = S_MUTE; m_ph = 0; m_gc = 0;
    end else begin
      case (m_st)
        S_IDLE: if (go) begin
          m_st = S_RUN; m_rem = int'(bus.div); m_ph = 1;
        end
        S_RUN: begin
          term = (m_rem == 1);
          if (!go && (!m_ph || term)) begin
            m_st = S_IDLE; m_ph = 0;
          end else if (term) begin
            m_ph = !m_ph; m_rem = int'(bus.div);
          end else begin
            m_rem--;
            if (!go) m_st = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (m_rem == 1) begin
            m_st = S_IDLE; m_ph = 0;
          end else begin
            m_rem--;
          end
        end
        default: begin
          if (m_gc == GAP - 1) begin
            if (go) begin
              m_st = S_RUN; m_rem = int'(bus.div); m_ph = 1;
            end else begin
              m_st = S_IDLE;
            end
          end else begin
            m_gc++;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    model_edge();
    e.b = m_buz;
    e.a = (m_st != S_IDLE);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    g.b = bus.buzzer;
    g.a = bus.active;
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL sb cyc=%0d got buz=%b act=%b want buz=%b act=%b",
               cyc, g.b, g.a, e.b, e.a);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic count_more(input logic v, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (bus.buzzer !== v) return;
      n++;
    end
    total++;
    bad++;
    $display("FAIL run_timeout got=%0d want=<200", n);
  endtask

  task automatic drive(input bit r, input bit en, input int d,
                       input int vol, input bit rt);
    rst        = r;
    bus.enable = en;
    bus.div    = W'(d);
    bus.volume = VB'(vol);
    bus.retrig = rt;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 3, 0);
    step();
    step();
    rst = 0;
  endtask

  seg_t segs[$];
  int n;
  int h;

  initial begin
    segs = '{
      '{1, 0, 0, 0, 0, 3},
      '{0, 1, 4, 3, 0, 20},
      '{0, 1, 6, 3, 0, 14},
      '{0, 1, 5, 1, 0, 30},
      '{0, 0, 5, 1, 0, 12},
      '{0, 1, 8, 0, 0, 40},
      '{0, 1, 8, 2, 1, 1},
      '{0, 1, 8, 2, 0, 9},
      '{0, 1, 8, 2, 1, 1},
      '{0, 1, 8, 2, 0, 30},
      '{0, 1, 3, 3, 1, 1},
      '{0, 0, 3, 3, 0, 20},
      '{0, 1, 1, 3, 0, 10},
      '{0, 1, 0, 3, 0, 8},
      '{0, 1, 7, 3, 0, 9},
      '{1, 1, 5, 3, 0, 1},
      '{0, 1, 0, 3, 0, 6}
    };
    drive(1, 0, 0, 0, 0);

    // reset state
    step();
    chk("rst_buz", int'(bus.buzzer), 0);
    chk("rst_act", int'(bus.active), 0);

    foreach (segs[s]) begin
      for (int k = 0; k < segs[s].n; k++) begin
        drive(segs[s].r, segs[s].en, segs[s].div,
              segs[s].vol, (k == 0) ? segs[s].rt : 1'b0);
        step();
      end
    end

    // basic 4/4 square, first high one cycle after start
    do_reset();
    drive(0, 1, 4, 3, 0);
    step();
    chk("t1_start_buz", int'(bus.buzzer), 0);
    chk("t1_start_act", int'(bus.active), 1);
    step();
    chk("t1_first_high", int'(bus.buzzer), 1);
    count_more(1, n);
    chk("t1_high_len", n + 1, 4);
    count_more(0, n);
    chk("t1_low_len", n + 1, 4);
    count_more(1, n);
    chk("t1_high2_len", n + 1, 4);

    // div change two cycles into a high half
    do_reset();
    drive(0, 1, 4, 3, 0);
    step();
    step();
    step();
    bus.div = W'(6);
    count_more(1, n);
    chk("t2_high_old", n + 2, 4);
    count_more(0, n);
    chk("t2_low_new", n + 1, 6);
    count_more(1, n);
    chk("t2_high_new", n + 1, 6);

    // disable one cycle into high half drains it
    do_reset();
    drive(0, 1, 8, 3, 0);
    step();
    step();
    bus.enable = 0;
    count_more(1, n);
    chk("t3_drain_len", n + 1, 8);
    chk("t3_drain_act", int'(bus.active), 0);
    // disable during low half stops next edge
    drive(0, 1, 4, 3, 0);
    step();
    step();
    count_more(1, n);
    bus.enable = 0;
    step();
    chk("t3_low_stop_act", int'(bus.active), 0);
    chk("t3_low_stop_buz", int'(bus.buzzer), 0);

    // volume 0: two PWM slots per 16-cycle period
    do_reset();
    drive(0, 1, 8, 0, 0);
    repeat (3) step();
    h = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      h += int'(bus.buzzer);
    end
    chk("t4_vol0_highs", h, 2);
    bus.volume = VB'(3);
    h = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      h += int'(bus.buzzer);
    end
    chk("t4_vol3_highs", h, 8);

    // retrigger gap and its extension
    do_reset();
    drive(0, 1, 4, 3, 0);
    step();
    step();
    bus.retrig = 1;
    step();
    bus.retrig = 0;
    step();
    chk("t5_gap_start", int'(bus.buzzer), 0);
    count_more(0, n);
    chk("t5_gap_len", n + 1, GAP);
    chk("t5_restart_high", int'(bus.buzzer), 1);
    bus.retrig = 1;
    step();
    bus.retrig = 0;
    h = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      h += int'(!bus.buzzer);
    end
    bus.retrig = 1;
    step();
    bus.retrig = 0;
    h += int'(!bus.buzzer);
    count_more(0, n);
    chk("t5_ext_gap_len", h + n, 26);

    // reset mid-run, then div=0 stays idle
    do_reset();
    drive(0, 1, 4, 3, 0);
    step();
    step();
    chk("t6_pre_buz", int'(bus.buzzer), 1);
    rst = 1;
    step();
    chk("t6_rst_buz", int'(bus.buzzer), 0);
    chk("t6_rst_act", int'(bus.active), 0);
    drive(0, 1, 0, 3, 0);
    h = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      h += int'(bus.buzzer) + int'(bus.active);
    end
    chk("t6_div0_idle", h, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
